// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S microphone receiver.
// Holds default parameter values and the channel encoding.
package i2s_pkg;

    localparam int unsigned I2S_CLK_DIV_DEF  = 50;
    localparam int unsigned I2S_SAMPLE_W_DEF = 16;
    localparam int unsigned I2S_SLOT_W_DEF   = 32;
    localparam int unsigned I2S_CHANNELS_DEF = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bus clock generator: divider, bclk, lrclk, bit counter, rise tick.
// Ports: clk, rst (sync, active-high), enable; bclk, lrclk, rise_tick, bit_cnt.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = I2S_CLK_DIV_DEF,
    parameter int unsigned SLOT_W  = I2S_SLOT_W_DEF,
    localparam int unsigned DIV_W  = $clog2(CLK_DIV),
    localparam int unsigned BIT_W  = $clog2(SLOT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             bclk,
    output logic             lrclk,
    output logic             rise_tick,
    output logic [BIT_W-1:0] bit_cnt
);

    logic             run_q, run_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             div_end;
    logic             fall_tick;

    // run_q spends the first enabled cycle arming the divider so the
    // first bclk rise lands exactly CLK_DIV cycles after enable.
    assign div_end   = enable && run_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_tick = div_end && !bclk_q;
    assign fall_tick = div_end && bclk_q;

    always_comb begin
        run_d   = run_q;
        div_d   = div_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        bit_d   = bit_q;
        if (!enable) begin
            run_d   = 1'b0;
            div_d   = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            bit_d   = '0;
        end else if (!run_q) begin
            run_d = 1'b1;
        end else if (div_end) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (rise_tick) begin
            bit_d = (bit_q == BIT_W'(SLOT_W - 1)) ? '0 : bit_q + 1'b1;
        end
        // bit_cnt is only 0 at a fall tick right after the last slot bit.
        if (fall_tick && (bit_q == '0)) begin
            lrclk_d = ~lrclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            div_q   <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            bit_q   <= '0;
        end else begin
            run_q   <= run_d;
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            bit_q   <= bit_d;
        end
    end

    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: captures slot bits, presents words via valid/ready.
// Ports: clk, rst (sync, active-high), enable, sd; bclk, lrclk, sample_data,
// sample_ch, sample_valid, sample_ready (in), overrun.
// Option: define I2S_RX_OVERRUN_CNT_EN to add overrun_cnt[15:0] (saturating).
module i2s_mic_rx
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV  = I2S_CLK_DIV_DEF,
    parameter int unsigned SAMPLE_W = I2S_SAMPLE_W_DEF,
    parameter int unsigned SLOT_W   = I2S_SLOT_W_DEF,
    parameter int unsigned CHANNELS = I2S_CHANNELS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                sd,
    output logic                bclk,
    output logic                lrclk,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ch,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
`ifdef I2S_RX_OVERRUN_CNT_EN
   ,output logic [15:0]         overrun_cnt
`endif
);

    localparam int unsigned BIT_W = $clog2(SLOT_W);

    logic             rise_tick;
    logic [BIT_W-1:0] bit_cnt;
    logic             slot_on;
    logic             in_word;

    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                pend_q, pend_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    i2s_ch_e             ch_q, ch_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV),
        .SLOT_W  (SLOT_W)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .rise_tick (rise_tick),
        .bit_cnt   (bit_cnt)
    );

    // Mono builds only keep left slots.
    assign slot_on = (CHANNELS == 1) ? !lrclk : 1'b1;
    // Bit 0 is the I2S delay bit; bits past SAMPLE_W are dropped.
    assign in_word = (bit_cnt != '0) && (bit_cnt <= BIT_W'(SAMPLE_W));

    always_comb begin
        shift_d = shift_q;
        pend_d  = 1'b0;
        if (!enable) begin
            shift_d = '0;
        end else if (rise_tick && slot_on && in_word) begin
            shift_d = {shift_q[SAMPLE_W-2:0], sd};
            pend_d  = (bit_cnt == BIT_W'(SAMPLE_W));
        end
    end

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (pend_q) begin
            data_d  = shift_q;
            ch_d    = i2s_ch_e'(lrclk);
            valid_d = 1'b1;
            ovr_d   = valid_q && !sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            ch_q    <= CH_LEFT;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_ch    = ch_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [15:0] ocnt_q, ocnt_d;

    always_comb begin
        ocnt_d = ocnt_q;
        if (ovr_d && (ocnt_q != 16'hFFFF)) begin
            ocnt_d = ocnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
        end
    end

    assign overrun_cnt = ocnt_q;
`endif

endmodule

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: clk cycles per bclk half-period; legal range >= 2.
REQ-002 SHALL have parameter SAMPLE_W, default 16: captured bits per slot; legal range 8..SLOT_W-1.
REQ-003 SHALL have parameter SLOT_W, default 32: bclk periods per channel slot; frame = 2*SLOT_W bclk periods.
REQ-004 SHALL have parameter CHANNELS, default 2: 1 = left only, 2 = stereo.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: high runs the bus, low stops it.
REQ-008 SHALL have port sd, input, 1 bit: microphone serial data.
REQ-009 SHALL have port bclk, output, 1 bit: registered bit clock.
REQ-010 SHALL have port lrclk, output, 1 bit: registered word select; 0 = left, 1 = right.
REQ-011 SHALL have port sample_data, output, SAMPLE_W bits: received word, MSB first as sent, raw two's complement.
REQ-012 SHALL have port sample_ch, output, 1 bit: channel of sample_data; 0 = left, 1 = right.
REQ-013 SHALL have port sample_valid, output, 1 bit: holding register is full.
REQ-014 SHALL have port sample_ready, input, 1 bit: consumer accepts the word.
REQ-015 SHALL have port overrun, output, 1 bit: one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-016 SHALL toggle bclk after every CLK_DIV clk cycles while enable is high; first rising edge CLK_DIV cycles after enable is first sampled high.
REQ-017 SHALL sample sd in the clk cycle in which the bclk register goes 0->1 (rise tick); bit_cnt advances 0..SLOT_W-1 on rise ticks, wrapping.
REQ-018 SHALL toggle lrclk on the fall tick following bit_cnt = SLOT_W-1; lrclk is 0 in the first slot after enable.
REQ-019 SHALL discard slot bit 0 (I2S one-bit delay), shift bits 1..SAMPLE_W MSB first, and ignore bits SAMPLE_W+1..SLOT_W-1.
REQ-020 SHALL load the holding register and assert sample_valid one clk after the rise tick capturing bit SAMPLE_W; sample_ch = lrclk of that slot.
REQ-021 SHALL, with CHANNELS=1, capture only lrclk=0 slots; right slots produce no word.
REQ-022 SHALL transfer a word when sample_valid and sample_ready are both high, clearing sample_valid next cycle unless a new word loads in that cycle.
REQ-023 SHALL, when a load coincides with valid&&!ready, overwrite the word and pulse overrun for one cycle.
REQ-024 SHALL, when a load coincides with valid&&ready, accept the old word, load the new one, keep sample_valid high and not pulse overrun.
REQ-025 SHALL, on enable low, on the next clk edge drive bclk=0 and lrclk=0, zero the divider, bit counter and shift register, and discard a partial word; the holding register and its handshake keep operating.

Reset
REQ-026 SHALL on rst drive bclk, lrclk, sample_data, sample_ch, sample_valid and overrun to 0 and clear all counters, at the next clk edge, including mid-frame.
REQ-027 SHALL give rst priority over enable, sample_ready and load events.

Configuration
REQ-028 SHALL provide macro I2S_RX_OVERRUN_CNT_EN; when defined, adds output overrun_cnt [15:0], which increments on each overrun pulse, saturates at 0xFFFF and clears on rst.
REQ-029 SHALL, without I2S_RX_OVERRUN_CNT_EN, omit the overrun_cnt port and logic entirely; all other behaviour is identical.

Structure
REQ-030 SHALL place default parameter constants and a channel typedef (CH_LEFT=0, CH_RIGHT=1) in shared package i2s_pkg.
REQ-031 SHALL implement divider, bclk/lrclk and rise/fall tick strobes in sub-module i2s_clkgen; capture and handshake live in i2s_mic_rx.

Verification
REQ-032 SHALL cover: CLK_DIV=50, enable high -> bclk period 100 clk, lrclk period 6400 clk.
REQ-033 SHALL cover: left slot bits 1..16 = 0xA5C3, right = 0x3C5A, ready tied high -> words 0xA5C3 ch0 then 0x3C5A ch1, each valid one cycle.
REQ-034 SHALL cover: ready held low across two words -> overrun pulses once, sample_data holds the second word.
REQ-035 SHALL cover: ready rising in the same cycle as a new load -> no overrun, valid stays high, the new word is presented.
REQ-036 SHALL cover: CHANNELS=1, SAMPLE_W=24, left 0x800001 -> one word 0x800001 per frame, no ch1 words.
REQ-037 SHALL cover: rst or enable low at bit_cnt=9 -> bclk/lrclk 0 next edge, no partial word emitted; after restart, the first word is correct.
